// File: rtl/result_display_mux.sv
// Result history and multiplexed 7-segment display driver with heartbeat.
// Newest classification result is shown on digit 0; older results shift toward higher digits.
module result_display_mux #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned RESULT_W         = 4,
  parameter int unsigned REFRESH_DIV      = 1000,
  parameter int unsigned HEARTBEAT_DIV    = 25000000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 result_valid,
  input  logic [RESULT_W-1:0]                  result_in,
  input  logic                                 clear,
  input  logic                                 blank_en,
  output logic [6:0]                           seg,
  output logic [NUM_DIGITS-1:0]                an,
  output logic                                 heartbeat,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      history_count
);

  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HB_W  = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [RESULT_W-1:0]   code_q [NUM_DIGITS];
  logic [RESULT_W-1:0]   code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_DIGITS-1:0] onehot;

  // Active-low {g,f,e,d,c,b,a}; invalid entries and non-decimal codes are blank.
  function automatic logic [6:0] seg_decode(input logic [RESULT_W-1:0] code, input logic v);
    logic [6:0] s;
    s = SEG_BLANK;
    if (v && (code <= RESULT_W'(9))) begin
      case (code[3:0])
        4'd0:    s = 7'b100_0000;
        4'd1:    s = 7'b111_1001;
        4'd2:    s = 7'b010_0100;
        4'd3:    s = 7'b011_0000;
        4'd4:    s = 7'b001_1001;
        4'd5:    s = 7'b001_0010;
        4'd6:    s = 7'b000_0010;
        4'd7:    s = 7'b111_1000;
        4'd8:    s = 7'b000_0000;
        4'd9:    s = 7'b001_0000;
        default: s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

  // History shift register, refresh/heartbeat counters and output stage next-state.
  always_comb begin
    code_d   = code_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ref_d    = ref_q + REF_W'(1);
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_q;
    onehot   = NUM_DIGITS'(1) << idx_q;

    if (clear) begin
      valid_d = '0;
      cnt_d   = '0;
    end else if (result_valid) begin
      code_d[0]  = result_in;
      valid_d[0] = 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        code_d[i]  = code_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      if (cnt_q != CNT_W'(NUM_DIGITS)) cnt_d = cnt_q + CNT_W'(1);
    end

    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (hb_cnt_q == HB_W'(HEARTBEAT_DIV - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end

    if (blank_en) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end else begin
      seg_d = seg_decode(code_q[idx_q], valid_q[idx_q]);
      an_d  = ANODE_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= '0;
      valid_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      ref_q    <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
    end else begin
      code_q   <= code_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ref_q    <= ref_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg           = seg_q;
  assign an            = an_q;
  assign heartbeat     = hb_q;
  assign history_count = cnt_q;

endmodule
